boundary_filter_stream: RTL and testbench

BOUNDARY_FILTER_STREAM -- requirements
Module: boundary_filter_stream

---
 rtl/boundary_pkg.sv | 11 +
 rtl/gray_div3.sv | 19 +
 rtl/boundary_filter_stream.sv | 152 +++++++++++++++
 tb/tb_boundary_filter_stream.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boundary_pkg.sv
// Shared definitions for the boundary filter: output mode encodings.
package boundary_pkg;

  typedef enum logic [1:0] {
    MODE_SUPPRESS = 2'd0,
    MODE_BINARY   = 2'd1,
    MODE_OVERLAY  = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_e;

endpackage

// File: rtl/gray_div3.sv
// Exact gray conversion: floor((R+G+B)/3), purely combinational.
module gray_div3 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  output logic [DATA_W-1:0] gray
);

  localparam logic [DATA_W+1:0] THREE = 3;

  logic [DATA_W+1:0] sum;

  assign sum  = {2'b00, red} + {2'b00, green} + {2'b00, blue};
  // Quotient of a (3*max) sum by 3 always fits back in DATA_W bits.
  assign gray = DATA_W'(sum / THREE);

endmodule

// File: rtl/boundary_filter_stream.sv
// Two-stage streaming edge filter: S1 registers gray + sideband, S2 decides
// edge/no-edge, forms the output pixel and keeps the per-frame edge count.
module boundary_filter_stream
  import boundary_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  input  logic              i_sof,
  input  logic              i_eol,
  input  logic              i_eof,
  input  logic [DATA_W-1:0] i_threshold,
  input  logic [1:0]        i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic [CNT_W-1:0]  o_edge_count,
  output logic              o_count_valid
);

  logic [DATA_W-1:0] gray_in;
  logic [DATA_W-1:0] prev_gray, thr;
  mode_e             mode;
  logic              line_start;
  logic [CNT_W-1:0]  cnt;

  logic              s1_full, s1_first, s1_sof, s1_eol, s1_eof;
  logic [DATA_W-1:0] s1_gray, s1_prev, s1_r, s1_g, s1_b, s1_thr;
  mode_e             s1_mode;

  logic              s2_adv, in_fire, s1_move, eof_out, is_edge;
  logic [DATA_W-1:0] grad, pix_r, pix_g, pix_b;
  logic [CNT_W-1:0]  cnt_base, cnt_next;

  gray_div3 #(.DATA_W(DATA_W)) u_gray (
    .red   (iRed),
    .green (iGreen),
    .blue  (iBlue),
    .gray  (gray_in)
  );

  assign s2_adv   = !o_valid || i_ready;
  assign o_ready  = !i_rst && (!s1_full || s2_adv);
  assign in_fire  = i_valid && o_ready;
  assign s1_move  = s1_full && s2_adv;
  assign eof_out  = o_valid && i_ready && o_eof;

  assign grad     = s1_first ? '0 :
                    (s1_gray >= s1_prev) ? s1_gray - s1_prev : s1_prev - s1_gray;
  assign is_edge  = grad > s1_thr;

  // A new frame entering S2, or the old frame's eof leaving, restarts from zero.
  assign cnt_base = (s1_sof || eof_out) ? '0 : cnt;
  assign cnt_next = (is_edge && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;

  always_comb begin
    pix_r = is_edge ? '0 : s1_gray;
    pix_g = is_edge ? '0 : s1_gray;
    pix_b = is_edge ? '0 : s1_gray;
    case (s1_mode)
      MODE_BINARY: begin
        pix_r = is_edge ? '1 : '0;
        pix_g = is_edge ? '1 : '0;
        pix_b = is_edge ? '1 : '0;
      end
      MODE_OVERLAY: begin
        pix_r = is_edge ? '0 : s1_r;
        pix_g = is_edge ? '0 : s1_g;
        pix_b = is_edge ? '0 : s1_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_full       <= 1'b0;
      o_valid       <= 1'b0;
      o_count_valid <= 1'b0;
      oRed          <= '0;
      oGreen        <= '0;
      oBlue         <= '0;
      o_sof         <= 1'b0;
      o_eol         <= 1'b0;
      o_eof         <= 1'b0;
      o_edge_count  <= '0;
      cnt           <= '0;
      thr           <= '0;
      mode          <= MODE_SUPPRESS;
      line_start    <= 1'b1;
      prev_gray     <= '0;
    end else begin
      o_count_valid <= 1'b0;

      if (in_fire) begin
        s1_gray    <= gray_in;
        s1_prev    <= prev_gray;
        s1_first   <= line_start || i_sof;
        s1_r       <= iRed;
        s1_g       <= iGreen;
        s1_b       <= iBlue;
        s1_sof     <= i_sof;
        s1_eol     <= i_eol;
        s1_eof     <= i_eof;
        // The sof beat itself already uses the newly latched settings.
        s1_thr     <= i_sof ? i_threshold : thr;
        s1_mode    <= i_sof ? mode_e'(i_mode) : mode;
        prev_gray  <= gray_in;
        line_start <= i_eol;
        if (i_sof) begin
          thr  <= i_threshold;
          mode <= mode_e'(i_mode);
        end
      end

      if (in_fire)      s1_full <= 1'b1;
      else if (s1_move) s1_full <= 1'b0;

      if (eof_out) begin
        o_edge_count  <= cnt;
        o_count_valid <= 1'b1;
        cnt           <= '0;
      end

      if (s2_adv) begin
        o_valid <= s1_full;
        if (s1_full) begin
          oRed   <= pix_r;
          oGreen <= pix_g;
          oBlue  <= pix_b;
          o_sof  <= s1_sof;
          o_eol  <= s1_eol;
          o_eof  <= s1_eof;
          cnt    <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_boundary_filter_stream.sv
// Scoreboard bench: a frame-level reference model predicts every output pixel
// and every published edge count; a monitor pops and compares.
module tb_boundary_filter_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DATA_W-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic              i_sof = 1'b0, i_eol = 1'b0, i_eof = 1'b0;
  logic [DATA_W-1:0] i_threshold = '0;
  logic [1:0]        i_mode = '0;
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic [DATA_W-1:0] oRed, oGreen, oBlue;
  logic              o_sof, o_eol, o_eof;
  logic [CNT_W-1:0]  o_edge_count;
  logic              o_count_valid;

  boundary_filter_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .i_sof(i_sof), .i_eol(i_eol), .i_eof(i_eof),
    .i_threshold(i_threshold), .i_mode(i_mode),
    .o_valid(o_valid), .i_ready(i_ready),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_edge_count(o_edge_count), .o_count_valid(o_count_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [26:0] exp_q[$];
  int          cnt_q[$];
  int          out_log[$];
  int          cnt_log[$];

  int m_prev, m_thr, m_mode, m_cnt;
  bit m_line_start;

  int bp_mode = 0;  // 0: ready high, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_thr = 0; m_mode = 0; m_cnt = 0; m_line_start = 1;
    exp_q.delete();
    cnt_q.delete();
  endtask

  task automatic model_accept(input int r, input int g, input int b,
                              input bit sof, input bit eol, input bit eof,
                              input int thr, input int mode);
    int gray, grad, vr, vg, vb;
    bit e;
    if (sof) begin m_thr = thr; m_mode = mode; m_cnt = 0; end
    gray = (r + g + b) / 3;
    if (m_line_start || sof) grad = 0;
    else grad = (gray > m_prev) ? gray - m_prev : m_prev - gray;
    e = grad > m_thr;
    m_prev = gray;
    m_line_start = eol;
    case (m_mode)
      1:       begin vr = e ? 255 : 0; vg = vr; vb = vr; end
      2:       begin vr = e ? 0 : r; vg = e ? 0 : g; vb = e ? 0 : b; end
      default: begin vr = e ? 0 : gray; vg = vr; vb = vr; end
    endcase
    exp_q.push_back({vr[7:0], vg[7:0], vb[7:0], sof, eol, eof});
    if (e) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    if (eof) begin cnt_q.push_back(m_cnt); m_cnt = 0; end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input int r, input int g, input int b,
                      input bit sof, input bit eol, input bit eof,
                      input int thr, input int mode);
    bit acc = 0;
    int n = 0;
    iRed = r[7:0]; iGreen = g[7:0]; iBlue = b[7:0];
    i_sof = sof; i_eol = eol; i_eof = eof;
    i_threshold = thr[7:0]; i_mode = mode[1:0];
    i_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
      n++;
    end
    i_valid = 1'b0;
    if (acc) model_accept(r, g, b, sof, eol, eof, thr, mode);
    else begin
      total++; bad++;
      $display("FAIL accept_timeout: o_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic send_g(input int gr, input bit sof, input bit eol, input bit eof,
                        input int thr, input int mode);
    send(gr, gr, gr, sof, eol, eof, thr, mode);
  endtask

  task automatic drain();
    int n = 0;
    bp_mode = 0;
    while ((exp_q.size() != 0 || cnt_q.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("drain_left", exp_q.size() + cnt_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      1:       i_ready = ($urandom_range(0, 99) < 60);
      2:       i_ready = 1'b0;
      default: i_ready = 1'b1;
    endcase
  end

  initial begin : monitor
    logic [26:0] cur, held;
    bit hold_prev;
    hold_prev = 0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {oRed, oGreen, oBlue, o_sof, o_eol, o_eof};
      if (i_rst) hold_prev = 0;
      else begin
        if (hold_prev) check("stall_hold", {5'b0, cur}, {5'b0, held});
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_beat: got %0h expected none", cur);
          end else check("pixel", {5'b0, cur}, {5'b0, exp_q.pop_front()});
          out_log.push_back(int'(oRed));
        end
        hold_prev = o_valid && !i_ready;
        held = cur;
        if (o_count_valid) begin
          if (cnt_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_count: got %0d expected no pulse", o_edge_count);
          end else check("edge_count", o_edge_count, cnt_q.pop_front());
          cnt_log.push_back(int'(o_edge_count));
        end
      end
    end
  end

  initial begin
    int lines, ppl, r, g, b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_ready", o_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_outputs", {oRed, oGreen, oBlue, o_sof, o_eol, o_eof}, 0);
    check("rst_count", {o_edge_count, o_count_valid}, 0);
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", o_ready, 1);

    // Backpressure on a short line: gray 10,10,30,31, thr 8
    out_log.delete();
    fork
      begin
        send_g(10, 1, 0, 0, 8, 0); send_g(10, 0, 0, 0, 8, 0);
        send_g(30, 0, 0, 0, 8, 0); send_g(31, 0, 1, 1, 8, 0);
      end
      begin
        repeat (2) @(posedge clk);
        bp_mode = 2;
        repeat (3) @(posedge clk);
        bp_mode = 0;
      end
    join
    drain();
    check("bp_len", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("bp_px0", out_log[0], 10); check("bp_px1", out_log[1], 10);
      check("bp_px2", out_log[2], 0);  check("bp_px3", out_log[3], 31);
    end

    // Line start: gray 200 ends line 1, line 2 starts at 0
    send_g(200, 1, 1, 0, 8, 1); send_g(0, 0, 0, 0, 8, 1); send_g(0, 0, 1, 1, 8, 1);
    drain();

    // Modes on (90,90,90) then (120,60,0)
    out_log.delete();
    send(90, 90, 90, 1, 0, 0, 8, 1); send(120, 60, 0, 0, 1, 1, 8, 1);
    send(90, 90, 90, 1, 0, 0, 8, 2); send(120, 60, 0, 0, 1, 1, 8, 2);
    drain();
    if (out_log.size() == 4) begin
      check("mode1_px1", out_log[1], 255);
      check("mode2_px0", out_log[2], 90);
      check("mode2_px1", out_log[3], 0);
    end else check("mode_len", out_log.size(), 4);

    // Threshold equality and mid-frame threshold change
    out_log.delete();
    send_g(10, 1, 0, 0, 8, 0); send_g(18, 0, 0, 0, 0, 0); send_g(20, 0, 1, 1, 0, 0);
    send_g(10, 1, 0, 0, 0, 0); send_g(12, 0, 1, 1, 8, 0);
    drain();
    if (out_log.size() == 5) begin
      check("thr_eq", out_log[1], 18);
      check("thr_latched", out_log[2], 20);
      check("thr_new_frame", out_log[4], 0);
    end else check("thr_len", out_log.size(), 5);

    // Counter: 2 edges, then 5 edges saturating, then single-pixel frame
    cnt_log.delete();
    send_g(0, 1, 0, 0, 8, 0); send_g(50, 0, 0, 0, 8, 0);
    send_g(50, 0, 0, 0, 8, 0); send_g(100, 0, 1, 1, 8, 0);
    send_g(0, 1, 0, 0, 8, 0);
    for (int i = 0; i < 5; i++) send_g((i % 2 == 0) ? 50 : 0, 0, i == 4, i == 4, 8, 0);
    send_g(77, 1, 1, 1, 8, 0);
    drain();
    if (cnt_log.size() == 3) begin
      check("count_two", cnt_log[0], 2);
      check("count_sat", cnt_log[1], 3);
      check("count_single", cnt_log[2], 0);
    end else check("count_len", cnt_log.size(), 3);

    // Reset with both stages full
    bp_mode = 2;
    @(posedge clk); #1;
    send_g(5, 1, 0, 0, 8, 0); send_g(90, 0, 0, 0, 8, 0);
    check("full_before_rst", {o_valid, o_ready}, 2'b10);
    i_rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_pulse", o_count_valid, 0);
    i_rst = 1'b0;
    bp_mode = 0;
    @(posedge clk); #1;
    check("midrst_ready_after", o_ready, 1);
    cnt_log.delete();
    send_g(0, 1, 0, 0, 8, 0); send_g(40, 0, 1, 1, 8, 0);
    drain();
    if (cnt_log.size() == 1) check("after_rst_count", cnt_log[0], 1);
    else check("after_rst_len", cnt_log.size(), 1);

    // Random frames under random backpressure
    bp_mode = 1;
    for (int f = 0; f < 15; f++) begin
      int thr, mode;
      thr = $urandom_range(0, 40);
      mode = $urandom_range(0, 3);
      lines = $urandom_range(1, 3);
      r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      for (int l = 0; l < lines; l++) begin
        ppl = $urandom_range(1, 5);
        for (int p = 0; p < ppl; p++) begin
          if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
          end
          send(r, g, b, (l == 0 && p == 0), (p == ppl - 1),
               (l == lines - 1 && p == ppl - 1),
               (l == 0 && p == 0) ? thr : $urandom_range(0, 255),
               (l == 0 && p == 0) ? mode : $urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
      bp_mode = 1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
